// File: rtl/array_update_stitch_pipeline.sv
// -----------------------------------------------------------------------------
// array_update_stitch_pipeline
//
// Pipelined writer for a small register array. It is the producer-side partner
// of the stitched, clamped array-index reader. Each valid request replaces
// element sel+1. A target past the last element is a no-op and is reported on
// `dropped`; it is never clamped. A valid `clr` zeroes the whole array instead
// of writing.
//
// Pipeline: p0 input register -> cycle0 index/oob logic -> p1 stage register
//           -> cycle1 commit into the state array, with p2 status loaded at
//           the same edge.
// Latency is 2 edges from the sampling edge to visible arr/out_valid. One
// request is accepted per cycle, and there is no backpressure.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request qualifier
//   sel        base index; the write target is sel+1
//   data       value to write
//   clr        when valid, zero the whole array instead of writing
//   arr        flattened array state; element i is at [ELEM_W*i +: ELEM_W]
//   out_valid  a request completed this cycle
//   dropped    the completed request was out of bounds and was not applied
//   out_idx    computed target index of the completed request
// -----------------------------------------------------------------------------
module array_update_stitch_pipeline #(
  parameter int ELEM_W    = 32,
  parameter int NUM_ELEMS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [1:0]                  sel,
  input  logic [ELEM_W-1:0]           data,
  input  logic                        clr,
  output logic [NUM_ELEMS*ELEM_W-1:0] arr,
  output logic                        out_valid,
  output logic                        dropped,
  output logic [2:0]                  out_idx
);

  // p0: input register
  logic              p0_valid;
  logic [1:0]        p0_sel;
  logic [ELEM_W-1:0] p0_data;
  logic              p0_clr;

  // p1: stage register
  logic              p1_valid;
  logic [2:0]        p1_idx;
  logic              p1_oob;
  logic [ELEM_W-1:0] p1_data;
  logic              p1_clr;

  // Architectural state
  logic [ELEM_W-1:0] state [NUM_ELEMS];

  // Cycle0 logic
  logic [2:0] idx;
  logic       oob;

  // NOTE: every signal written in always_comb gets a default first, so that
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    idx = 3'h0;
    oob = 1'b0;
    // The index is widened to 3 bits before the increment, so sel == 3 gives
    // 4 and does not wrap to 0.
    idx = {1'b0, p0_sel} + 3'h1;
    oob = (idx > 3'(NUM_ELEMS - 1));
  end

  // Valid bits carry reset, so in-flight requests are discarded on reset.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_valid <= 1'b0;
      p1_valid <= 1'b0;
    end else begin
      p0_valid <= in_valid;
      p1_valid <= p0_valid;
    end
  end

  // NOTE: payload registers have no reset. Their contents matter only when
  // the matching valid bit is set, and the valid bits do reset.
  always_ff @(posedge clk) begin
    p0_sel  <= sel;
    p0_data <= data;
    p0_clr  <= clr;
    p1_idx  <= idx;
    p1_oob  <= oob;
    p1_data <= p0_data;
    p1_clr  <= p0_clr;
  end

  // Cycle1 commit. This is the single in-order write point, so back-to-back
  // writes to the same element need no hazard logic: the later one wins.
  // NOTE: the state array is reset, unlike a RAM, because arr must read as
  // zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEMS; i++) state[i] <= '0;
    end else if (p1_valid) begin
      if (p1_clr) begin
        for (int i = 0; i < NUM_ELEMS; i++) state[i] <= '0;
      end else if (!p1_oob) begin
        state[p1_idx[1:0]] <= p1_data;
      end
      // An out-of-bounds write leaves the array unchanged (update semantics).
    end
  end

  // p2: completion status, loaded at the same edge as the commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dropped   <= 1'b0;
      out_idx   <= 3'h0;
    end else begin
      out_valid <= p1_valid;
      // clr overrides oob, so a clear is never reported as dropped.
      dropped   <= p1_valid & ~p1_clr & p1_oob;
      out_idx   <= p1_valid ? p1_idx : 3'h0;
    end
  end

  // Flatten the state array onto the output bus.
  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_flatten
    assign arr[g*ELEM_W +: ELEM_W] = state[g];
  end

endmodule

// File: tb/tb_array_update_stitch_pipeline.sv
// -----------------------------------------------------------------------------
// Testbench for array_update_stitch_pipeline.
// Stimulus pushes hand-computed expected completions into a queue. A separate
// monitor pops and compares on every cycle where out_valid is high.
// -----------------------------------------------------------------------------
module tb_array_update_stitch_pipeline;

  typedef struct packed {
    logic [2:0]   idx;
    logic         drop;
    logic [127:0] arr;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   sel;
  logic [31:0]  data;
  logic         clr;
  logic [127:0] arr;
  logic         out_valid;
  logic         dropped;
  logic [2:0]   out_idx;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  array_update_stitch_pipeline #(.ELEM_W(32), .NUM_ELEMS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel       (sel),
    .data      (data),
    .clr       (clr),
    .arr       (arr),
    .out_valid (out_valid),
    .dropped   (dropped),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: DUT outputs change on posedge and are sampled on negedge.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 128'(out_valid), 128'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_idx", 128'(out_idx), 128'(e.idx));
        check("dropped", 128'(dropped), 128'(e.drop));
        check("arr",     arr,           e.arr);
      end
    end
  end

  // One valid request, driven for the following posedge.
  task automatic issue(input logic [1:0] s, input logic [31:0] d, input logic c,
                       input logic [2:0] ei, input logic ed, input logic [127:0] ea);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    sel      = s;
    data     = d;
    clr      = c;
    e.idx  = ei;
    e.drop = ed;
    e.arr  = ea;
    exp_q.push_back(e);
  endtask

  // Invalid entry with hostile payload: must not touch the state.
  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    sel      = 2'd0;
    data     = 32'hFFFF_FFFF;
    clr      = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 2'd0;
    data     = 32'h0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle: the array stays zero and no completions appear.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_arr", arr, 128'h0);
      check("idle_out_valid", 128'(out_valid), 128'h0);
    end

    // sel 0,1,2 back to back: targets 1,2,3.
    issue(2'd0, 32'hA, 1'b0, 3'd1, 1'b0, {32'h0, 32'h0, 32'hA, 32'h0});
    issue(2'd1, 32'hB, 1'b0, 3'd2, 1'b0, {32'h0, 32'hB, 32'hA, 32'h0});
    issue(2'd2, 32'hC, 1'b0, 3'd3, 1'b0, {32'hC, 32'hB, 32'hA, 32'h0});
    bubble();
    // Out of bounds: reported, array unchanged.
    issue(2'd3, 32'hDEADBEEF, 1'b0, 3'd4, 1'b1, {32'hC, 32'hB, 32'hA, 32'h0});
    bubble();
    // Same element twice: first value visible, then the later one wins.
    issue(2'd1, 32'h1, 1'b0, 3'd2, 1'b0, {32'hC, 32'h1, 32'hA, 32'h0});
    issue(2'd1, 32'h2, 1'b0, 3'd2, 1'b0, {32'hC, 32'h2, 32'hA, 32'h0});
    // Clear with an out-of-bounds sel: never dropped. A write follows at once.
    issue(2'd3, 32'h77, 1'b1, 3'd4, 1'b0, 128'h0);
    issue(2'd0, 32'h5, 1'b0, 3'd1, 1'b0, {32'h0, 32'h0, 32'h5, 32'h0});
    bubble();
    drain();
    check("after_drain_arr", arr, {32'h0, 32'h0, 32'h5, 32'h0});

    // Reset with two requests in flight: neither may commit.
    issue(2'd1, 32'h1111, 1'b0, 3'd0, 1'b0, 128'h0);
    issue(2'd2, 32'h2222, 1'b0, 3'd0, 1'b0, 128'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    #1;
    check("reset_async_arr", arr, 128'h0);
    check("reset_async_out_valid", 128'(out_valid), 128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_reset_arr", arr, 128'h0);
      check("post_reset_out_valid", 128'(out_valid), 128'h0);
    end

    // Normal operation resumes after reset.
    issue(2'd2, 32'h33, 1'b0, 3'd3, 1'b0, {32'h33, 32'h0, 32'h0, 32'h0});
    bubble();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
